// File: rtl/uart_tx_sched.sv
// uart_tx_sched: serialises handshaked bytes into start/data/parity/stop bits paced by baud_tick
module uart_tx_sched #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy
);
  localparam int CW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic                 par, par_d, stop, stop_d, line_d;

  assign tx_ready = state == IDLE;
  assign busy     = state != IDLE;

  // state and datapath registers; the line is registered so it only moves after a tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      shift  <= '0;
      cnt    <= '0;
      par    <= 1'b0;
      stop   <= 1'b0;
      tx_out <= 1'b1;
    end else begin
      state  <= state_d;
      shift  <= shift_d;
      cnt    <= cnt_d;
      par    <= par_d;
      stop   <= stop_d;
      tx_out <= line_d;
    end

  // next state and next line level; everything except the IDLE handshake advances only on a tick
  always_comb begin
    state_d = state;
    shift_d = shift;
    cnt_d   = cnt;
    par_d   = par;
    stop_d  = stop;
    line_d  = tx_out;
    case (state)
      IDLE:
        if (tx_valid) begin
          state_d = ALIGN;
          shift_d = tx_data;
          par_d   = ^tx_data ^ 1'(PARITY_ODD);
          line_d  = 1'b1;
        end
      ALIGN:
        if (baud_tick) begin
          state_d = START;
          line_d  = 1'b0;
        end
      START:
        if (baud_tick) begin
          state_d = DATA;
          line_d  = shift[0];
          cnt_d   = '0;
        end
      DATA:
        if (baud_tick) begin
          if (cnt == CW'(DATA_BITS - 1)) begin
            state_d = PARITY_EN != 0 ? PARITY : STOP;
            line_d  = PARITY_EN != 0 ? par : 1'b1;
            stop_d  = 1'b0;
          end else begin
            shift_d = shift >> 1;
            cnt_d   = cnt + 1'b1;
            line_d  = shift[1];
          end
        end
      PARITY:
        if (baud_tick) begin
          state_d = STOP;
          line_d  = 1'b1;
          stop_d  = 1'b0;
        end
      STOP:
        if (baud_tick) begin
          state_d = stop == 1'(STOP_BITS - 1) ? IDLE : STOP;
          stop_d  = 1'b1;
          line_d  = 1'b1;
        end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized scoreboard bench over four parameter sets sharing clock, reset and tick
module tb_uart_tx_sched;
  localparam int N = 4;
  localparam int DBV[N] = '{8, 8, 8, 9};
  localparam int PEV[N] = '{0, 1, 1, 1};
  localparam int POV[N] = '{0, 0, 1, 1};
  localparam int SBV[N] = '{1, 2, 1, 2};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         baud_tick = 1'b0;
  logic [N-1:0] tx_valid_v = '0;
  logic [8:0]   tx_data_v [N];
  logic [N-1:0] tx_ready_v, tx_out_v, busy_v;

  logic run = 1'b0;
  logic force_tick = 1'b0;
  int   per = 4;
  int   tc = 0;

  int   n_chk = 0;
  int   n_pass = 0;

  int   pend [N];
  bit   ln [N];
  bit   lq [N][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gu
    uart_tx_sched #(
      .DATA_BITS(DBV[g]), .PARITY_EN(PEV[g]), .PARITY_ODD(POV[g]), .STOP_BITS(SBV[g])
    ) u (
      .clk(clk),
      .rst_n(rst_n),
      .baud_tick(baud_tick),
      .tx_valid(tx_valid_v[g]),
      .tx_data(tx_data_v[g][DBV[g]-1:0]),
      .tx_ready(tx_ready_v[g]),
      .tx_out(tx_out_v[g]),
      .busy(busy_v[g])
    );
  end

  // baud strobe: periodic while run is set, or a single forced pulse
  always begin
    @(posedge clk);
    #1;
    baud_tick = force_tick || (run && tc == 0);
    tc = (tc + 1 >= per) ? 0 : tc + 1;
  end

  task automatic chk(input int i, input string nm, input logic a, input logic e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL u%0d %s got %0b expected %0b at %0t", i, nm, a, e, $time);
  endtask

  // scoreboard monitor: a handshake pushes the frame's line bits; each counted tick pops the next one
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        pend[i] = 0;
        ln[i] = 1'b1;
        lq[i].delete();
      end
      chk(i, "tx_out", tx_out_v[i], ln[i]);
      chk(i, "busy", busy_v[i], pend[i] > 0);
      chk(i, "tx_ready", tx_ready_v[i], pend[i] == 0);
      if (rst_n) begin
        if (pend[i] > 0) begin
          if (baud_tick) begin
            pend[i]--;
            ln[i] = lq[i].size() > 0 ? lq[i].pop_front() : 1'b1;
          end
        end else if (tx_valid_v[i]) begin
          bit p;
          p = POV[i] != 0;
          lq[i].push_back(1'b0);
          for (int b = 0; b < DBV[i]; b++) begin
            lq[i].push_back(tx_data_v[i][b]);
            p ^= tx_data_v[i][b];
          end
          if (PEV[i] != 0) lq[i].push_back(p);
          for (int s = 0; s < SBV[i]; s++) lq[i].push_back(1'b1);
          pend[i] = 2 + DBV[i] + PEV[i] + SBV[i];
        end
      end
    end
  end

  task automatic send(input int i, input logic [8:0] d, input bit hold);
    bit got = 0;
    tx_valid_v[i] = 1'b1;
    tx_data_v[i] = d;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      got = tx_ready_v[i] && rst_n;
    end
    if (!got) begin
      $display("FAIL u%0d handshake timeout at %0t", i, $time);
      $fatal(1, "handshake timeout");
    end
    @(posedge clk);
    #2;
    if (!hold) tx_valid_v[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    bit idle = 0;
    for (int n = 0; n < 5000 && !idle; n++) begin
      @(negedge clk);
      idle = !busy_v[i];
    end
    if (!idle) begin
      $display("FAIL u%0d idle timeout at %0t", i, $time);
      $fatal(1, "idle timeout");
    end
  endtask

  task automatic wait_ticks(input int k);
    int seen = 0;
    for (int n = 0; n < 5000 && seen < k; n++) begin
      @(negedge clk);
      if (baud_tick) seen++;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) tx_data_v[i] = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    run = 1'b1;
    repeat (50) @(posedge clk);
    #2;
    send(0, 9'h0A5, 0);
    wait_idle(0);
    send(1, 9'h0A5, 0);
    wait_idle(1);
    send(2, 9'h001, 0);
    wait_idle(2);
    send(1, 9'h001, 0);
    wait_idle(1);
    send(3, 9'h1A5, 0);
    wait_idle(3);
    // back-to-back with valid held, then data churn while busy
    send(1, 9'h000, 1);
    send(1, 9'h0FF, 0);
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #2 tx_data_v[1] = 9'($urandom);
      tx_valid_v[1] = n < 3;
    end
    tx_valid_v[1] = 1'b0;
    wait_idle(1);
    // tick coincident with the handshake cycle
    @(posedge clk);
    #2 run = 1'b0;
    force_tick = 1'b1;
    @(posedge clk);
    #2 force_tick = 1'b0;
    tx_valid_v[0] = 1'b1;
    tx_data_v[0] = 9'h05A;
    @(posedge clk);
    #2 tx_valid_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 run = 1'b1;
    wait_idle(0);
    // tick stall mid-DATA
    send(2, 9'($urandom), 0);
    wait_ticks(5);
    @(posedge clk);
    #2 run = 1'b0;
    repeat (100) @(posedge clk);
    #2 run = 1'b1;
    wait_idle(2);
    // reset during the fourth data bit, then a clean frame
    send(0, 9'h0C3, 0);
    wait_ticks(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    send(0, 9'h03C, 0);
    wait_idle(0);
    // random traffic with random baud periods
    for (int n = 0; n < 40; n++) begin
      per = $urandom_range(2, 6);
      send($urandom_range(0, N - 1), 9'($urandom), 0);
      repeat ($urandom_range(0, 10)) @(posedge clk);
      #2;
    end
    for (int i = 0; i < N; i++) wait_idle(i);
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
